// File: rtl/patgen_pkg.sv
// Shared types and constants for the multi-mode pattern generator.
package patgen_pkg;

  typedef enum logic [2:0] {
    MODE_STATIC = 3'd0,
    MODE_COUNT  = 3'd1,
    MODE_WALK1  = 3'd2,
    MODE_ALT    = 3'd3,
    MODE_PRBS   = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // Alternating 0101... start pattern; callers keep the low WIDTH bits (WIDTH <= 64).
  function automatic logic [63:0] alt_start();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i += 2) begin
      r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/patgen_lfsr.sv
// Combinational Fibonacci LFSR step: shift left, feedback parity of tapped bits into bit 0.
module patgen_lfsr #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic [WIDTH-1:0] cur_i,
  output logic [WIDTH-1:0] nxt_o
);

  assign nxt_o = {cur_i[WIDTH-2:0], ^(cur_i & LFSR_TAPS)};

endmodule

// File: rtl/pattern_gen_multi.sv
// Multi-mode test pattern source with valid/ready output and accepted-beat counter.
// Optional PATGEN_ERR_INJECT_EN adds err_inject to flip bit 0 of one accepted beat.
module pattern_gen_multi
  import patgen_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PATGEN_ERR_INJECT_EN
  input  logic             err_inject,
`endif
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic             pattern_ready,
  output logic             pattern_valid,
  output logic [WIDTH-1:0] pattern,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             busy
);

  localparam logic [63:0]      AltFull  = alt_start();
  localparam logic [WIDTH-1:0] AltStart = AltFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0] One      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q;
  mode_e            mode_q;
  mode_e            mode_sel;
  logic             valid_q;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] pat_adv;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] prbs_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             hs;

  assign hs            = valid_q & pattern_ready;
  assign pattern_valid = valid_q;
  assign busy          = valid_q;
  assign beat_cnt      = cnt_q;

  // Undefined mode codes fall back to STATIC.
  assign mode_sel = (mode > 3'd4) ? MODE_STATIC : mode_e'(mode);

  patgen_lfsr #(
    .WIDTH    (WIDTH),
    .LFSR_TAPS(LFSR_TAPS)
  ) u_lfsr (
    .cur_i(pat_q),
    .nxt_o(prbs_nxt)
  );

  always_comb begin
    start_val = seed;
    unique case (mode_sel)
      MODE_WALK1: start_val = One;
      MODE_ALT:   start_val = AltStart;
      MODE_PRBS:  start_val = (seed == '0) ? One : seed;
      default:    start_val = seed;
    endcase
  end

  always_comb begin
    pat_adv = pat_q;
    unique case (mode_q)
      MODE_COUNT: pat_adv = pat_q + One;
      MODE_WALK1: pat_adv = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
      MODE_ALT:   pat_adv = ~pat_q;
      MODE_PRBS:  pat_adv = prbs_nxt;
      default:    pat_adv = pat_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_STATIC;
      valid_q <= 1'b0;
      pat_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q <= ST_RUN;
            mode_q  <= mode_sel;
            pat_q   <= start_val;
            valid_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (hs) pat_q <= pat_adv;
          if (!enable) begin
            state_q <= hs ? ST_IDLE : ST_DRAIN;
            valid_q <= !hs;
          end
        end
        ST_DRAIN: begin
          // Last beat is held until taken; enable is ignored here.
          if (hs) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (hs) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef PATGEN_ERR_INJECT_EN
  logic err_q;

  // One error per arm: further pulses while armed are absorbed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (!err_q && err_inject) begin
      err_q <= 1'b1;
    end else if (err_q && hs) begin
      err_q <= 1'b0;
    end
  end

  assign pattern = pat_q ^ {{(WIDTH-1){1'b0}}, err_q};
`else
  assign pattern = pat_q;
`endif

endmodule
